// File: rtl/snn_host_pkg.sv
// Shared op codes, control codes and FSM states for the SNN host driver.
package snn_host_pkg;

    localparam logic [2:0] OP_RUN     = 3'b010;
    localparam logic [2:0] CTRL_IDLE  = 3'b010;
    localparam logic [2:0] CTRL_INPUT = 3'b000;
    localparam int         CNT_W      = 11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN_IN,
        RUN_EXEC,
        RUN_WAIT,
        DONE
    } state_t;

    function automatic logic is_run(input logic [2:0] op);
        return op == OP_RUN;
    endfunction

endpackage

// File: rtl/spike_tally.sv
// Per-neuron saturating spike counters with a lowest-index-wins argmax.
module spike_tally #(
    parameter int OUTPUTS  = 8,
    parameter int CNT_BITS = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          sample,
    input  logic [OUTPUTS-1:0]            spikes,
    output logic [OUTPUTS*CNT_BITS-1:0]   counts,
    output logic [$clog2(OUTPUTS)-1:0]    best
);

    localparam int                  CLS_W   = $clog2(OUTPUTS);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic [CNT_BITS-1:0] best_val;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            counts <= '0;
        end else if (sample) begin
            for (int i = 0; i < OUTPUTS; i++) begin
                if (spikes[i] && counts[i*CNT_BITS +: CNT_BITS] != CNT_MAX) begin
                    counts[i*CNT_BITS +: CNT_BITS] <= counts[i*CNT_BITS +: CNT_BITS] + CNT_BITS'(1);
                end
            end
        end
    end

    // Strict greater-than keeps the earliest index on ties.
    always_comb begin
        best     = '0;
        best_val = counts[0 +: CNT_BITS];
        for (int i = 1; i < OUTPUTS; i++) begin
            if (counts[i*CNT_BITS +: CNT_BITS] > best_val) begin
                best_val = counts[i*CNT_BITS +: CNT_BITS];
                best     = CLS_W'(i);
            end
        end
    end

endmodule

// File: rtl/snn_host_driver.sv
// Host-side sequencer: streams setup bytes and timestep inputs into the SNN and tallies output spikes.
module snn_host_driver
    import snn_host_pkg::*;
#(
    parameter int INPUT_BYTES = 2,
    parameter int OUTPUTS     = 8,
    parameter int CNT_BITS    = 8,
    parameter int SPIKE_LAT   = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [2:0]                  cmd_op,
    input  logic [10:0]                 cmd_len,
    input  logic                        byte_valid,
    output logic                        byte_ready,
    input  logic [7:0]                  byte_data,
    output logic [7:0]                  snn_data,
    output logic [2:0]                  snn_ctrl,
    output logic                        snn_execute,
    input  logic [OUTPUTS-1:0]          snn_spikes,
    output logic                        res_valid,
    output logic [$clog2(OUTPUTS)-1:0]  res_class,
    output logic [OUTPUTS*CNT_BITS-1:0] res_counts,
    output logic                        busy
);

    localparam logic [CNT_W-1:0] IN_LAST   = CNT_W'(INPUT_BYTES - 1);
    localparam logic [2:0]       WAIT_LAST = 3'(SPIKE_LAT - 1);

    state_t           state;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] step_cnt;
    logic [2:0]       wait_cnt;
    logic             tally_clear;
    logic             tally_sample;

    assign cmd_ready    = (state == IDLE);
    assign byte_ready   = (state == LOAD) || (state == RUN_IN);
    assign busy         = (state != IDLE);
    assign tally_clear  = (state == IDLE) && cmd_valid && is_run(cmd_op);
    assign tally_sample = (state == RUN_WAIT) && (wait_cnt == WAIT_LAST);

    // Pins default to the no-write code every cycle; a state only overrides them for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= '0;
            len_q       <= '0;
            byte_cnt    <= '0;
            step_cnt    <= '0;
            wait_cnt    <= '0;
            snn_data    <= '0;
            snn_ctrl    <= CTRL_IDLE;
            snn_execute <= 1'b0;
            res_valid   <= 1'b0;
        end else begin
            snn_data    <= '0;
            snn_ctrl    <= CTRL_IDLE;
            snn_execute <= 1'b0;
            res_valid   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q     <= cmd_op;
                        len_q    <= cmd_len;
                        byte_cnt <= '0;
                        step_cnt <= '0;
                        wait_cnt <= '0;
                        if (is_run(cmd_op)) begin
                            if (cmd_len == '0) begin
                                state     <= DONE;
                                res_valid <= 1'b1;
                            end else begin
                                state <= RUN_IN;
                            end
                        end else if (cmd_len != '0) begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (byte_valid) begin
                        snn_data <= byte_data;
                        snn_ctrl <= op_q;
                        if (byte_cnt == len_q - CNT_W'(1)) begin
                            byte_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                RUN_IN: begin
                    if (byte_valid) begin
                        snn_data <= byte_data;
                        snn_ctrl <= CTRL_INPUT;
                        if (byte_cnt == IN_LAST) begin
                            byte_cnt <= '0;
                            state    <= RUN_EXEC;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                RUN_EXEC: begin
                    snn_execute <= 1'b1;
                    state       <= RUN_WAIT;
                end
                RUN_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        if (step_cnt == len_q - CNT_W'(1)) begin
                            state     <= DONE;
                            res_valid <= 1'b1;
                        end else begin
                            step_cnt <= step_cnt + CNT_W'(1);
                            state    <= RUN_IN;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    spike_tally #(
        .OUTPUTS  (OUTPUTS),
        .CNT_BITS (CNT_BITS)
    ) u_tally (
        .clk    (clk),
        .reset  (reset),
        .clear  (tally_clear),
        .sample (tally_sample),
        .spikes (snn_spikes),
        .counts (res_counts),
        .best   (res_class)
    );

endmodule

// File: tb/tb_snn_host_driver.sv
// Directed bench for snn_host_driver: setup-byte vector table plus hand-written RUN sequences.
module tb_snn_host_driver;
    import snn_host_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'b000;
    logic [10:0] cmd_len = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [7:0]  byte_data = 8'h00;
    logic [7:0]  snn_data;
    logic [2:0]  snn_ctrl;
    logic        snn_execute;
    logic [7:0]  snn_spikes = 8'h00;
    logic        res_valid;
    logic [2:0]  res_class;
    logic [63:0] res_counts;
    logic        busy;

    int checks = 0;
    int errors = 0;

    snn_host_driver #(
        .INPUT_BYTES (2),
        .OUTPUTS     (8),
        .CNT_BITS    (8),
        .SPIKE_LAT   (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_len     (cmd_len),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .byte_data   (byte_data),
        .snn_data    (snn_data),
        .snn_ctrl    (snn_ctrl),
        .snn_execute (snn_execute),
        .snn_spikes  (snn_spikes),
        .res_valid   (res_valid),
        .res_class   (res_class),
        .res_counts  (res_counts),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Network model: on each execute pulse present the next timestep's spike pattern and log pin activity.
    logic [7:0] spike_pat [8];
    bit         use_const = 1'b0;
    logic [7:0] const_pat = 8'h00;
    int         run_base = 0;
    int         exec_seen = 0;
    int         in_writes = 0;
    int         long_pulses = 0;
    int         bad_exec_ctrl = 0;
    logic       prev_exec = 1'b0;

    always @(negedge clk) begin
        if (snn_execute) begin
            snn_spikes = use_const ? const_pat : spike_pat[(exec_seen - run_base) & 7];
            exec_seen++;
            if (prev_exec) long_pulses++;
            if (snn_ctrl != CTRL_IDLE) bad_exec_ctrl++;
        end
        if (snn_ctrl == CTRL_INPUT) in_writes++;
        prev_exec = snn_execute;
    end

    typedef struct {
        logic        cv;
        logic [2:0]  op;
        logic [10:0] len;
        logic        bv;
        logic [7:0]  bd;
        logic [2:0]  e_ctrl;
        logic [7:0]  e_data;
        logic        e_busy;
        logic        e_cready;
        logic        e_bready;
    } vec_t;

    vec_t vecs [16];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        cmd_valid  = v.cv;
        cmd_op     = v.op;
        cmd_len    = v.len;
        byte_valid = v.bv;
        byte_data  = v.bd;
    endtask

    task automatic do_run(input logic [10:0] len, input int budget, output bit got);
        run_base = exec_seen;
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_op     = OP_RUN;
        cmd_len    = len;
        byte_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            if (res_valid) got = 1'b1;
            else begin
                @(negedge clk);
                byte_data = byte_data + 8'h11;
            end
        end
        byte_valid = 1'b0;
        check_output("run_done_seen", 64'(got), 64'd1);
        @(negedge clk);
        check_output("res_valid_one_cycle", 64'(res_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit got;
        int wr0;
        bit seen_bad;

        vecs[0]  = '{1'b1, 3'b001, 11'd3, 1'b0, 8'h00, 3'b010, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 3'b001, 11'd3, 1'b1, 8'hA1, 3'b001, 8'hA1, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 3'b001, 11'd3, 1'b1, 8'hB2, 3'b001, 8'hB2, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 3'b001, 11'd3, 1'b1, 8'hC3, 3'b001, 8'hC3, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 3'b001, 11'd3, 1'b0, 8'h00, 3'b010, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 3'b110, 11'd2, 1'b0, 8'h00, 3'b010, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 3'b110, 11'd2, 1'b1, 8'h5A, 3'b110, 8'h5A, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 3'b110, 11'd2, 1'b0, 8'h00, 3'b010, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 3'b110, 11'd2, 1'b0, 8'h00, 3'b010, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 3'b110, 11'd2, 1'b1, 8'h6B, 3'b110, 8'h6B, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 3'b110, 11'd2, 1'b0, 8'h00, 3'b010, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 3'b011, 11'd0, 1'b0, 8'h00, 3'b010, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 3'b011, 11'd0, 1'b1, 8'hFF, 3'b010, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 3'b100, 11'd1, 1'b0, 8'h00, 3'b010, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 3'b111, 11'd5, 1'b1, 8'h77, 3'b100, 8'h77, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 3'b111, 11'd5, 1'b0, 8'h00, 3'b010, 8'h00, 1'b0, 1'b1, 1'b0};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_ctrl", 64'(snn_ctrl), 64'h2);
        check_output("rst_data", 64'(snn_data), 64'h0);
        check_output("rst_exec", 64'(snn_execute), 64'h0);
        check_output("rst_res_valid", 64'(res_valid), 64'h0);
        check_output("rst_class", 64'(res_class), 64'h0);
        check_output("rst_counts", res_counts, 64'h0);
        check_output("rst_busy", 64'(busy), 64'h0);
        check_output("rst_cmd_ready", 64'(cmd_ready), 64'h1);
        check_output("rst_byte_ready", 64'(byte_ready), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Setup-byte streaming, cycle by cycle
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(vecs[i]);
            @(posedge clk);
            #1;
            check_output($sformatf("v%0d_ctrl", i), 64'(snn_ctrl), 64'(vecs[i].e_ctrl));
            check_output($sformatf("v%0d_data", i), 64'(snn_data), 64'(vecs[i].e_data));
            check_output($sformatf("v%0d_exec", i), 64'(snn_execute), 64'h0);
            check_output($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
            check_output($sformatf("v%0d_cmd_ready", i), 64'(cmd_ready), 64'(vecs[i].e_cready));
            check_output($sformatf("v%0d_byte_ready", i), 64'(byte_ready), 64'(vecs[i].e_bready));
        end

        // RUN len=4: bit 5 every step, bit 2 on steps 0 and 2
        spike_pat[0] = 8'h24; spike_pat[1] = 8'h20; spike_pat[2] = 8'h24; spike_pat[3] = 8'h20;
        use_const = 1'b0;
        wr0 = in_writes;
        do_run(11'd4, 200, got);
        check_output("r4_counts", res_counts, 64'h0000_0400_0002_0000);
        check_output("r4_class", 64'(res_class), 64'd5);
        check_output("r4_exec_pulses", 64'(exec_seen - run_base), 64'd4);
        check_output("r4_input_writes", 64'(in_writes - wr0), 64'd8);
        check_output("r4_pulse_width", 64'(long_pulses), 64'd0);
        check_output("r4_exec_ctrl", 64'(bad_exec_ctrl), 64'd0);

        // Results hold across an unrelated setup command
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'b111; cmd_len = 11'd1;
        @(negedge clk);
        cmd_valid = 1'b0; byte_valid = 1'b1; byte_data = 8'h42;
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_output("hold_counts", res_counts, 64'h0000_0400_0002_0000);
        check_output("hold_class", 64'(res_class), 64'd5);

        // Tie between neurons 3 and 6
        spike_pat[0] = 8'h48; spike_pat[1] = 8'h02; spike_pat[2] = 8'h48; spike_pat[3] = 8'h00;
        do_run(11'd4, 200, got);
        check_output("tie_counts", res_counts, 64'h0002_0000_0200_0100);
        check_output("tie_class", 64'(res_class), 64'd3);

        // Zero-length RUN clears previous results
        do_run(11'd0, 10, got);
        check_output("r0_counts", res_counts, 64'h0);
        check_output("r0_class", 64'(res_class), 64'd0);
        check_output("r0_exec_pulses", 64'(exec_seen - run_base), 64'd0);

        // Long RUN saturates the counter
        use_const = 1'b1; const_pat = 8'h01;
        do_run(11'd300, 5000, got);
        check_output("sat_counts", res_counts, 64'h0000_0000_0000_00FF);
        check_output("sat_class", 64'(res_class), 64'd0);
        check_output("sat_exec_pulses", 64'(exec_seen - run_base), 64'd300);
        check_output("sat_pulse_width", 64'(long_pulses), 64'd0);

        // Byte stalls inside RUN_IN hold off execute
        const_pat = 8'h80;
        run_base = exec_seen;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_RUN; cmd_len = 11'd1; byte_valid = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        byte_valid = 1'b1; byte_data = 8'h13;
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_output("stall_no_exec", 64'(exec_seen - run_base), 64'd0);
        check_output("stall_busy", 64'(busy), 64'd1);
        byte_valid = 1'b1; byte_data = 8'h14;
        @(negedge clk);
        byte_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (res_valid) got = 1'b1;
            else @(negedge clk);
        end
        check_output("stall_done_seen", 64'(got), 64'd1);
        check_output("stall_exec_pulses", 64'(exec_seen - run_base), 64'd1);
        check_output("stall_counts", res_counts, 64'h0100_0000_0000_0000);
        check_output("stall_class", 64'(res_class), 64'd7);

        // Reset during RUN_IN of the second timestep
        const_pat = 8'hFF;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_RUN; cmd_len = 11'd4; byte_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (snn_execute) got = 1'b1;
            else @(negedge clk);
        end
        byte_valid = 1'b0;
        check_output("abort_first_exec", 64'(got), 64'd1);
        repeat (2) @(negedge clk);
        check_output("abort_pre_count0", 64'(res_counts[7:0]), 64'd1);
        check_output("abort_pre_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_output("abort_busy", 64'(busy), 64'd0);
        check_output("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        check_output("abort_ctrl", 64'(snn_ctrl), 64'h2);
        check_output("abort_data", 64'(snn_data), 64'h0);
        check_output("abort_counts", res_counts, 64'h0);
        check_output("abort_class", 64'(res_class), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        byte_valid = 1'b1;
        seen_bad = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (res_valid || snn_execute || busy) seen_bad = 1'b1;
        end
        byte_valid = 1'b0;
        check_output("abort_quiet", 64'(seen_bad), 64'd0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'b101; cmd_len = 11'd1;
        @(negedge clk);
        cmd_valid = 1'b0; byte_valid = 1'b1; byte_data = 8'h3C;
        @(posedge clk);
        #1;
        check_output("post_abort_ctrl", 64'(snn_ctrl), 64'h5);
        check_output("post_abort_data", 64'(snn_data), 64'h3C);
        @(negedge clk);
        byte_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snn_host_driver.md
SNN_HOST_DRIVER -- requirements
Module: snn_host_driver

Interface
REQ-001 Parameters SHALL be: INPUT_BYTES, default 2, input bytes per timestep; OUTPUTS, default 8, output neurons tallied; CNT_BITS, default 8, spike-counter width; SPIKE_LAT, default 1, cycles from execute pulse to spike sample (1..7).
REQ-002 clk  in  1  clock; all logic on the rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 cmd_valid/cmd_ready  in/out  1/1  command handshake; transfer when both are high.
REQ-005 cmd_op  in  3  setup code 000/001/011/100/101/110/111, or 010 = RUN.
REQ-006 cmd_len  in  11  byte count for setup ops; timestep count for RUN.
REQ-007 byte_valid/byte_ready  in/out  1/1  payload byte handshake.
REQ-008 byte_data  in  8  payload byte.
REQ-009 snn_data  out  8  registered byte to network data pins.
REQ-010 snn_ctrl  out  3  registered setup_control code to network.
REQ-011 snn_execute  out  1  registered execute pin to network.
REQ-012 snn_spikes  in  OUTPUTS  last-layer spike outputs from network.
REQ-013 res_valid  out  1  one-cycle pulse at RUN completion.
REQ-014 res_class  out  clog2(OUTPUTS)  index of the neuron with the highest count.
REQ-015 res_counts  out  OUTPUTS*CNT_BITS  per-neuron spike counts; neuron i occupies bits [i*CNT_BITS +: CNT_BITS].
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, RUN_IN, RUN_EXEC, RUN_WAIT and DONE.
REQ-018 cmd_ready SHALL be high only in IDLE; byte_ready SHALL be high only in LOAD and RUN_IN.
REQ-019 Whenever no byte is being written, snn_ctrl SHALL be 010 (the network's no-write code) and snn_data SHALL be 0x00.
REQ-020 A setup command with cmd_len>0 SHALL enter LOAD; a setup command with cmd_len=0 SHALL remain in IDLE with no pin activity.
REQ-021 In LOAD, each accepted byte SHALL appear for exactly one cycle on the next cycle as snn_data=byte_data, snn_ctrl=cmd_op, snn_execute=0; when byte_valid is low the pins SHALL hold the idle values.
REQ-022 After the cmd_len-th accepted byte, LOAD SHALL return to IDLE.
REQ-023 RUN with cmd_len=T>0 SHALL clear all counters, then per timestep run these steps in order:
- RUN_IN: accept INPUT_BYTES bytes, each driven one cycle with snn_ctrl=000.
- RUN_EXEC: one cycle with snn_execute=1 and snn_ctrl=010.
- RUN_WAIT: SPIKE_LAT cycles with execute=0; on the last of these cycles, sample snn_spikes.
REQ-024 On each sample, counter i SHALL increment by snn_spikes[i], saturating at 2^CNT_BITS-1 with no wrap.
REQ-025 After timestep T, the FSM SHALL enter DONE, assert res_valid for one cycle, then return to IDLE.
REQ-026 res_class SHALL be the index with the largest count, with the lowest index winning ties.
REQ-027 res_class and res_counts SHALL hold their values until the next RUN starts.
REQ-028 RUN with cmd_len=0 SHALL go directly to DONE with all counts 0 and res_class 0.
REQ-029 A byte stall in RUN_IN SHALL hold the timestep; execute SHALL NOT pulse until all INPUT_BYTES bytes are accepted.
REQ-030 Byte and step counters SHALL be 11 bits; cmd_op and cmd_len SHALL be latched at command acceptance.

Reset
REQ-031 On reset: state=IDLE, snn_data=0x00, snn_ctrl=010, snn_execute=0, res_valid=0, res_class=0, res_counts=0, busy=0, all internal counters=0.
REQ-032 Reset asserted mid-LOAD or mid-RUN SHALL abort the operation on the next edge, with no further pin activity and no res_valid.

Structure
REQ-033 Package snn_host_pkg SHALL hold the op-code constants (including OP_RUN=010 and CTRL_IDLE=010) and the FSM state enum.
REQ-034 Sub-module spike_tally SHALL hold the saturating counters and the argmax; the FSM SHALL stay in snn_host_driver.

Verification
REQ-035 Setup op=001, len=3, bytes A1,B2,C3 each valid every cycle -> three consecutive cycles of snn_ctrl=001 with data A1,B2,C3, then snn_ctrl=010, then IDLE.
REQ-036 Setup op=110, len=2, byte_valid gapped by 2 cycles -> exactly 2 write cycles and idle code between them.
REQ-037 RUN len=4, spike model asserts bit 5 on every sample and bit 2 on two samples -> res_counts[5]=4, [2]=2, others 0; res_class=5; exactly 4 execute pulses, each one cycle.
REQ-038 RUN len=300, CNT_BITS=8, bit 0 always spiking -> count 255 (saturated) and res_class=0.
REQ-039 Tie case: bits 3 and 6 each spike twice -> res_class=3.
REQ-040 Reset during RUN_IN of timestep 2 -> outputs return to reset values next cycle, no res_valid, and a new command is accepted.
